datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 133 +++++++++++++
 tb/tb_datapath.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-bus processor datapath: MAR/MDR/SP/PC/T/IR, an 8x16 register file,
// an 8-function ALU and a branch-condition evaluator over the internal bus.
module datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        tmar,
  input  logic        tmdr,
  input  logic        tsp,
  input  logic        tpc,
  input  logic        tir,
  input  logic        ldmar,
  input  logic        ldmdr,
  input  logic        ldsp,
  input  logic        ldpc,
  input  logic        ldt,
  input  logic        ldir,
  input  logic        memrd,
  input  logic        memwr,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  input  logic        m2,
  input  logic [2:0]  fnotsel_cont,
  input  logic [15:0] Dbusin,
  output logic [15:0] Abus,
  output logic [15:0] Dbusout,
  output logic [3:0]  ir1,
  output logic [2:0]  ir2,
  output logic        dcond
);

  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] sp_q,  sp_d;
  logic [15:0] pc_q,  pc_d;
  logic [15:0] t_q,   t_d;
  logic [15:0] ir_q,  ir_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];

  logic [2:0]  reg_addr;
  logic [15:0] rf_rdata;
  logic [15:0] alu_b;
  logic [15:0] alu_y;
  logic [15:0] bus;

  // Register-file read port, ALU and bus source selection.
  always_comb begin
    reg_addr = m1 ? ir_q[11:9] : ir_q[8:6];
    rf_rdata = rf_q[reg_addr];
    alu_b    = m2 ? 16'h0001 : rf_rdata;

    alu_y = t_q;
    case (fnotsel_cont)
      3'b000:  alu_y = t_q + alu_b;
      3'b001:  alu_y = t_q - alu_b;
      3'b010:  alu_y = t_q & alu_b;
      3'b011:  alu_y = t_q | alu_b;
      3'b100:  alu_y = t_q ^ alu_b;
      3'b101:  alu_y = ~t_q;
      3'b110:  alu_y = alu_b;
      default: alu_y = t_q;
    endcase

    // Fixed-priority bus driver; the ALU owns the bus when nothing else does.
    if (tmdr)      bus = mdr_q;
    else if (tsp)  bus = sp_q;
    else if (tpc)  bus = pc_q;
    else if (tir)  bus = {{7{ir_q[8]}}, ir_q[8:0]};
    else if (rd)   bus = rf_rdata;
    else           bus = alu_y;
  end

  always_comb begin
    Abus    = tmar  ? mar_q : 16'h0000;
    Dbusout = memwr ? mdr_q : 16'h0000;
    ir1     = ir_q[15:12];
    ir2     = ir_q[11:9];

    dcond = 1'b0;
    case (ir2)
      3'b000:  dcond = 1'b1;
      3'b001:  dcond = (bus == 16'h0000);
      3'b010:  dcond = (bus != 16'h0000);
      3'b011:  dcond = bus[15];
      3'b100:  dcond = !bus[15] && (bus != 16'h0000);
      3'b101:  dcond = !bus[15];
      3'b110:  dcond = bus[15] || (bus == 16'h0000);
      default: dcond = 1'b0;
    endcase
  end

  always_comb begin
    mar_d = ldmar ? bus : mar_q;
    sp_d  = ldsp  ? bus : sp_q;
    pc_d  = ldpc  ? bus : pc_q;
    t_d   = ldt   ? bus : t_q;
    ir_d  = ldir  ? bus : ir_q;
    // A memory read beats a bus load into MDR.
    if (memrd)      mdr_d = Dbusin;
    else if (ldmdr) mdr_d = bus;
    else            mdr_d = mdr_q;
    for (int i = 0; i < 8; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wr) rf_d[reg_addr] = bus;

    if (rst) begin
      mar_d = 16'h0000;
      mdr_d = 16'h0000;
      sp_d  = 16'h0000;
      pc_d  = 16'h0000;
      t_d   = 16'h0000;
      ir_d  = 16'h0000;
      for (int i = 0; i < 8; i++) begin
        rf_d[i] = 16'h0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    mar_q <= mar_d;
    mdr_q <= mdr_d;
    sp_q  <= sp_d;
    pc_q  <= pc_d;
    t_q   <= t_d;
    ir_q  <= ir_d;
    for (int i = 0; i < 8; i++) begin
      rf_q[i] <= rf_d[i];
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Bench for the datapath: directed scenarios plus randomized control words
// checked cycle by cycle against a register-level behavioural model.
module tb_datapath;

  logic        clk;
  logic        rst;
  logic        tmar, tmdr, tsp, tpc, tir;
  logic        ldmar, ldmdr, ldsp, ldpc, ldt, ldir;
  logic        memrd, memwr, rd, wr, m1, m2;
  logic [2:0]  fnotsel_cont;
  logic [15:0] Dbusin;
  logic [15:0] Abus, Dbusout;
  logic [3:0]  ir1;
  logic [2:0]  ir2;
  logic        dcond;

  int tests_run = 0;
  int fails     = 0;

  // Behavioural model state
  logic [15:0] m_mar, m_mdr, m_sp, m_pc, m_t, m_ir;
  logic [15:0] m_r [8];

  datapath dut (
    .clk(clk), .rst(rst),
    .tmar(tmar), .tmdr(tmdr), .tsp(tsp), .tpc(tpc), .tir(tir),
    .ldmar(ldmar), .ldmdr(ldmdr), .ldsp(ldsp), .ldpc(ldpc), .ldt(ldt), .ldir(ldir),
    .memrd(memrd), .memwr(memwr), .rd(rd), .wr(wr), .m1(m1), .m2(m2),
    .fnotsel_cont(fnotsel_cont), .Dbusin(Dbusin),
    .Abus(Abus), .Dbusout(Dbusout), .ir1(ir1), .ir2(ir2), .dcond(dcond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_addr();
    return m1 ? m_ir[11:9] : m_ir[8:6];
  endfunction

  function automatic logic [15:0] model_alu();
    int a, b;
    a = int'(m_t);
    b = m2 ? 1 : int'(m_r[model_addr()]);
    case (fnotsel_cont)
      3'd0: return 16'((a + b) % 65536);
      3'd1: return 16'((a - b + 65536) % 65536);
      3'd2: return 16'(a & b);
      3'd3: return 16'(a | b);
      3'd4: return 16'(a ^ b);
      3'd5: return 16'(65535 - a);
      3'd6: return 16'(b);
      default: return 16'(a);
    endcase
  endfunction

  function automatic logic [15:0] model_bus();
    int sext;
    sext = (m_ir[8] ? -512 : 0) + int'(m_ir[8:0]);
    if (tmdr) return m_mdr;
    if (tsp)  return m_sp;
    if (tpc)  return m_pc;
    if (tir)  return 16'((sext + 65536) % 65536);
    if (rd)   return m_r[model_addr()];
    return model_alu();
  endfunction

  function automatic logic model_dcond();
    int sb;
    sb = $signed(model_bus());
    case (m_ir[11:9])
      3'd0: return 1'b1;
      3'd1: return sb == 0;
      3'd2: return sb != 0;
      3'd3: return sb < 0;
      3'd4: return sb > 0;
      3'd5: return sb >= 0;
      3'd6: return sb <= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] b;
    logic [2:0]  a;
    b = model_bus();
    a = model_addr();
    if (rst) begin
      {m_mar, m_mdr, m_sp, m_pc, m_t, m_ir} = '0;
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    end else begin
      if (ldmar) m_mar = b;
      if (ldsp)  m_sp  = b;
      if (ldpc)  m_pc  = b;
      if (ldt)   m_t   = b;
      if (ldir)  m_ir  = b;
      if (memrd) m_mdr = Dbusin;
      else if (ldmdr) m_mdr = b;
      if (wr) m_r[a] = b;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    rst = 0;
    {tmar, tmdr, tsp, tpc, tir} = '0;
    {ldmar, ldmdr, ldsp, ldpc, ldt, ldir} = '0;
    {memrd, memwr, rd, wr, m1, m2} = '0;
    fnotsel_cont = 3'd0;
    Dbusin = 16'h0000;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [15:0] v);
    memrd = 1; Dbusin = v;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; tmdr = 1; ldpc = 1;
    tick();
    rst = 1;
    tick();
    @(negedge clk);
    tests_run++;
    if (Abus !== 16'h0000) begin fails++; $display("FAIL reset_abus got %h want 0000", Abus); end
    tests_run++;
    if (ir1 !== 4'h0 || ir2 !== 3'h0) begin fails++; $display("FAIL reset_ir got %h/%h want 0/0", ir1, ir2); end
    tests_run++;
    if (dcond !== 1'b1) begin fails++; $display("FAIL reset_dcond got %b want 1", dcond); end
    tmar = 1; memwr = 1;
    @(negedge clk);
    tests_run++;
    if (Abus !== 16'h0000 || Dbusout !== 16'h0000) begin
      fails++; $display("FAIL reset_regs Abus=%h Dbusout=%h want 0000/0000", Abus, Dbusout);
    end
    idle();
  endtask

  task automatic test_mem_rw();
    load_mdr(16'h1234);
    memwr = 1;
    @(negedge clk);
    tests_run++;
    if (Dbusout !== 16'h1234) begin fails++; $display("FAIL mem_write got %h want 1234", Dbusout); end
    memwr = 0;
    @(negedge clk);
    tests_run++;
    if (Dbusout !== 16'h0000) begin fails++; $display("FAIL mem_write_off got %h want 0000", Dbusout); end
    idle();
  endtask

  task automatic test_pc_increment();
    load_mdr(16'h0005);
    tmdr = 1; ldpc = 1; tick();
    tpc = 1; ldt = 1; tick();
    m2 = 1; fnotsel_cont = 3'b000; ldpc = 1; tick();
    tpc = 1; ldmar = 1; tick();
    tmar = 1;
    @(negedge clk);
    tests_run++;
    if (Abus !== 16'h0006) begin fails++; $display("FAIL pc_increment got %h want 0006", Abus); end
    idle();
  endtask

  task automatic test_overflow_dcond();
    load_mdr(16'h0600);
    tmdr = 1; ldir = 1; tick();
    load_mdr(16'h7FFF);
    tmdr = 1; ldt = 1; tick();
    m2 = 1; fnotsel_cont = 3'b000; ldt = 1; tick();
    fnotsel_cont = 3'b111; ldsp = 1;
    @(negedge clk);
    tests_run++;
    if (dcond !== 1'b1 || ir2 !== 3'd3) begin
      fails++; $display("FAIL overflow_dcond dcond=%b ir2=%0d want 1/3", dcond, ir2);
    end
    tick();
    tsp = 1; ldmar = 1; tick();
    tmar = 1;
    @(negedge clk);
    tests_run++;
    if (Abus !== 16'h8000) begin fails++; $display("FAIL overflow_sp got %h want 8000", Abus); end
    idle();
  endtask

  task automatic test_regfile();
    load_mdr(16'h0200);
    tmdr = 1; ldir = 1; tick();
    load_mdr(16'h00AA);
    m1 = 1; tmdr = 1; wr = 1; tick();
    load_mdr(16'h5555);
    m1 = 1; rd = 1; ldt = 1; tick();
    fnotsel_cont = 3'b111; ldpc = 1; tick();
    tpc = 1; ldmar = 1; tick();
    tmar = 1;
    @(negedge clk);
    tests_run++;
    if (Abus !== 16'h00AA) begin fails++; $display("FAIL regfile_pc got %h want 00aa", Abus); end
    tests_run++;
    if (ir1 !== 4'h0 || ir2 !== 3'd1) begin fails++; $display("FAIL regfile_ir got %h/%h want 0/1", ir1, ir2); end
    idle();
  endtask

  task automatic test_priority();
    load_mdr(16'h0BEE);
    tmdr = 1; ldpc = 1; tick();
    load_mdr(16'h1234);
    tmdr = 1; tpc = 1; ldt = 1; tick();
    fnotsel_cont = 3'b111; ldmar = 1; tick();
    tmar = 1;
    @(negedge clk);
    tests_run++;
    if (Abus !== 16'h1234) begin fails++; $display("FAIL priority got %h want 1234", Abus); end
    idle();
  endtask

  task automatic test_reset_override();
    load_mdr(16'h00FF);
    tmdr = 1; ldpc = 1; ldmar = 1; rst = 1; tick();
    tpc = 1; ldmar = 1; tick();
    tmar = 1; memwr = 1;
    @(negedge clk);
    tests_run++;
    if (Abus !== 16'h0000) begin fails++; $display("FAIL reset_override_pc got %h want 0000", Abus); end
    tests_run++;
    if (Dbusout !== 16'h0000) begin fails++; $display("FAIL reset_override_mdr got %h want 0000", Dbusout); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      tmar  = $urandom_range(0, 1);
      tmdr  = ($urandom_range(0, 5) == 0);
      tsp   = ($urandom_range(0, 5) == 0);
      tpc   = ($urandom_range(0, 5) == 0);
      tir   = ($urandom_range(0, 5) == 0);
      rd    = ($urandom_range(0, 4) == 0);
      ldmar = $urandom_range(0, 1);
      ldmdr = ($urandom_range(0, 3) == 0);
      ldsp  = $urandom_range(0, 1);
      ldpc  = $urandom_range(0, 1);
      ldt   = $urandom_range(0, 1);
      ldir  = ($urandom_range(0, 3) == 0);
      memrd = ($urandom_range(0, 2) == 0);
      memwr = $urandom_range(0, 1);
      wr    = ($urandom_range(0, 2) == 0);
      m1    = $urandom_range(0, 1);
      m2    = $urandom_range(0, 1);
      fnotsel_cont = 3'($urandom_range(0, 7));
      Dbusin = 16'($urandom);
      @(negedge clk);
      tests_run++;
      if (Abus !== (tmar ? m_mar : 16'h0000)) begin
        fails++; $display("FAIL rand_abus cyc %0d got %h want %h", n, Abus, tmar ? m_mar : 16'h0000);
      end
      tests_run++;
      if (Dbusout !== (memwr ? m_mdr : 16'h0000)) begin
        fails++; $display("FAIL rand_dbusout cyc %0d got %h want %h", n, Dbusout, memwr ? m_mdr : 16'h0000);
      end
      tests_run++;
      if (ir1 !== m_ir[15:12] || ir2 !== m_ir[11:9]) begin
        fails++; $display("FAIL rand_ir cyc %0d got %h/%h want %h/%h", n, ir1, ir2, m_ir[15:12], m_ir[11:9]);
      end
      tests_run++;
      if (dcond !== model_dcond()) begin
        fails++; $display("FAIL rand_dcond cyc %0d got %b want %b", n, dcond, model_dcond());
      end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1;
    {m_mar, m_mdr, m_sp, m_pc, m_t, m_ir} = '0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    #1;
    test_reset();
    test_mem_rw();
    test_pc_increment();
    test_overflow_dcond();
    test_regfile();
    test_priority();
    test_reset_override();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
